// File: rtl/fak6509_pkg.sv
// Shared 6509 bank-unlock constants: state encoding, key bytes, bank register address, flag values.
// Also used by the adapter bank logic; the FAK6509_VERIFY_EN build adds the readback state.
package fak6509_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SAVE,
    ST_WR_K0,
    ST_WR_K1,
    ST_WR_K2,
    ST_WR_FLAG,
    ST_WR_RESTORE,
    ST_RD_VERIFY,
    ST_DONE
  } state_t;

  localparam logic [15:0] BANK_ADDR_DEF = 16'h0001;
  localparam logic [7:0]  KEY0_DEF      = 8'h55;
  localparam logic [7:0]  KEY1_DEF      = 8'hAA;
  localparam logic [7:0]  KEY2_DEF      = 8'h00;

  localparam logic FLAG_NIBBLE = 1'b0;
  localparam logic FLAG_FULL   = 1'b1;

  // Everything that changes together when a bus cycle is entered.
  typedef struct packed {
    state_t      state;
    logic [15:0] address;
    logic [7:0]  data_out;
    logic        r_w;
    logic        bus_en;
    logic        busy;
    logic        done;
  } bus_reg_t;

  // In nibble mode the responder only keeps the low four bank bits.
  function automatic logic [7:0] verify_expect(input logic full, input logic [7:0] saved);
    return (full == FLAG_FULL) ? saved : {4'h0, saved[3:0]};
  endfunction

endpackage

// File: rtl/bank_unlock_writer_if.sv
// Handshake and bus signals between the unlock sequencer (master) and its initiator/bus (slave).
interface bank_unlock_writer_if;
  logic        req;
  logic        full_en;
  logic        _rdy;
  logic [7:0]  data_in;
  logic [15:0] address;
  logic [7:0]  data_out;
  logic        r_w;
  logic        bus_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  saved_bank;

  modport master (
    input  req, full_en, _rdy, data_in,
    output address, data_out, r_w, bus_en, busy, done, err, saved_bank
  );

  modport slave (
    output req, full_en, _rdy, data_in,
    input  address, data_out, r_w, bus_en, busy, done, err, saved_bank
  );
endinterface

// File: rtl/bank_unlock_writer_rdy_timeout.sv
// Counts consecutive stalled (_rdy low) cycles of an owned bus cycle; flags the edge that hits the limit.
module rdy_timeout #(
  parameter int              CNT_W   = 8,
  parameter logic [CNT_W-1:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic rdy,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Asserted on the stalled edge that would take the count to TIMEOUT.
  assign expired = active && !rdy && (count == TIMEOUT - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!active || rdy || expired) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bank_unlock_writer.sv
// 6509 bank-register unlock sequencer: save bank, write key $55,$AA,$00,<flag>, restore, optional readback.
// Define FAK6509_VERIFY_EN to add the RD_VERIFY readback and report mismatch on err.
module bank_unlock_writer
  import fak6509_pkg::*;
#(
  parameter logic [15:0] BANK_ADDR = BANK_ADDR_DEF,
  parameter logic [7:0]  KEY0      = KEY0_DEF,
  parameter logic [7:0]  KEY1      = KEY1_DEF,
  parameter logic [7:0]  KEY2      = KEY2_DEF,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input logic                  phi2_6509,
  input logic                  _reset,
  bank_unlock_writer_if.master bus
);

  localparam bus_reg_t RST_VAL = '{state: ST_IDLE, address: 16'h0000, data_out: 8'h00,
                                   r_w: 1'b1, bus_en: 1'b0, busy: 1'b0, done: 1'b0};

  bus_reg_t   r;
  logic       flag;
  logic [7:0] saved_bank;
  logic       err;
  logic       expired;

  rdy_timeout #(.CNT_W(8), .TIMEOUT(TIMEOUT)) u_rdy_timeout (
    .clk     (phi2_6509),
    .rst_n   (_reset),
    .active  (r.bus_en),
    .rdy     (bus._rdy),
    .expired (expired)
  );

  // Registered outputs for the cycle that starts when state s is entered.
  function automatic bus_reg_t enter(input state_t s);
    bus_reg_t o;
    o = RST_VAL;
    o.state = s;
    case (s)
      ST_IDLE: ;
      ST_DONE: o.done = 1'b1;
      default: begin
        o.address = BANK_ADDR;
        o.bus_en  = 1'b1;
        o.busy    = 1'b1;
      end
    endcase
    case (s)
      ST_WR_K0:      begin o.r_w = 1'b0; o.data_out = KEY0;            end
      ST_WR_K1:      begin o.r_w = 1'b0; o.data_out = KEY1;            end
      ST_WR_K2:      begin o.r_w = 1'b0; o.data_out = KEY2;            end
      ST_WR_FLAG:    begin o.r_w = 1'b0; o.data_out = {7'b0, flag};    end
      ST_WR_RESTORE: begin o.r_w = 1'b0; o.data_out = saved_bank;      end
      default: ;
    endcase
    return o;
  endfunction

  always_ff @(posedge phi2_6509 or negedge _reset) begin
    if (!_reset) begin
      r          <= RST_VAL;
      flag       <= FLAG_NIBBLE;
      saved_bank <= 8'h00;
      err        <= 1'b0;
    end else begin
      case (r.state)
        ST_IDLE: begin
          if (bus.req) begin
            flag <= bus.full_en;
            err  <= 1'b0;
            r    <= enter(ST_RD_SAVE);
          end
        end
        ST_DONE: r <= enter(ST_IDLE);
        default: begin
          // Abort leaves a partial key behind; the responder drops it on the next non-key write.
          if (expired) begin
            err <= 1'b1;
            r   <= enter(ST_IDLE);
          end else if (bus._rdy) begin
            case (r.state)
              ST_RD_SAVE: begin
                saved_bank <= bus.data_in;
                r          <= enter(ST_WR_K0);
              end
              ST_WR_K0:   r <= enter(ST_WR_K1);
              ST_WR_K1:   r <= enter(ST_WR_K2);
              ST_WR_K2:   r <= enter(ST_WR_FLAG);
              ST_WR_FLAG: r <= enter(ST_WR_RESTORE);
`ifdef FAK6509_VERIFY_EN
              ST_WR_RESTORE: r <= enter(ST_RD_VERIFY);
              ST_RD_VERIFY: begin
                if (bus.data_in != verify_expect(flag, saved_bank)) err <= 1'b1;
                r <= enter(ST_DONE);
              end
`else
              ST_WR_RESTORE: r <= enter(ST_DONE);
`endif
              default: r <= enter(ST_IDLE);
            endcase
          end
        end
      endcase
    end
  end

  assign bus.address    = r.address;
  assign bus.data_out   = r.data_out;
  assign bus.r_w        = r.r_w;
  assign bus.bus_en     = r.bus_en;
  assign bus.busy       = r.busy;
  assign bus.done       = r.done;
  assign bus.err        = err;
  assign bus.saved_bank = saved_bank;

endmodule

// File: tb/tb_bank_unlock_writer.sv
// Scoreboard bench for bank_unlock_writer: directed sequences push expected bus cycles, a monitor pops them.
module tb_bank_unlock_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bank_unlock_writer_if bus();

  bank_unlock_writer dut (
    .phi2_6509 (clk),
    ._reset    (rst_n),
    .bus       (bus)
  );

`ifdef FAK6509_VERIFY_EN
  localparam int SEQ_LAT = 8;
  localparam bit VERIFY  = 1'b1;
`else
  localparam int SEQ_LAT = 7;
  localparam bit VERIFY  = 1'b0;
`endif

  typedef struct {
    bit          is_done;
    logic [15:0] addr;
    bit          rw;
    logic [7:0]  data;
    int          when;
    bit          err;
    logic [7:0]  saved;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         rd_idx = 0;
  logic [7:0] rd_save = 8'h00;
  logic [7:0] rd_ver = 8'h00;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Bus responder: first read of a sequence returns rd_save, later ones rd_ver.
  always @(negedge clk) begin
    if (bus.bus_en && bus.r_w) begin
      bus.data_in = (rd_idx == 0) ? rd_save : rd_ver;
      if (bus._rdy) rd_idx++;
    end else begin
      bus.data_in = 8'h00;
    end
  end

  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_n && bus.bus_en && bus._rdy) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_cycle", {bus.address, bus.r_w, bus.data_out}, 0);
      end else begin
        e = exp_q.pop_front();
        check(!e.is_done && bus.address == e.addr && bus.r_w == e.rw && (e.rw || bus.data_out == e.data),
              "bus_cycle", {bus.address, bus.r_w, bus.data_out}, {e.addr, e.rw, e.data});
      end
    end
    if (rst_n && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check(e.is_done, "done_order", 1, e.is_done);
        check(cyc == e.when, "done_latency", cyc, e.when);
        check(bus.err == e.err, "err_at_done", bus.err, e.err);
        check(bus.saved_bank == e.saved, "saved_bank", bus.saved_bank, e.saved);
        check(!bus.bus_en && !bus.busy, "done_bus_released", {bus.bus_en, bus.busy}, 0);
      end
    end
  end

  task automatic push_bus(input logic [15:0] addr, input bit rw, input logic [7:0] data);
    ev_t e;
    e = '{is_done: 1'b0, addr: addr, rw: rw, data: data, when: 0, err: 1'b0, saved: 8'h00};
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input bit full, input logic [7:0] save, input logic [7:0] ver, input int lat);
    ev_t        e;
    logic [7:0] want;
    want = full ? save : {4'h0, save[3:0]};
    push_bus(16'h0001, 1'b1, 8'h00);
    push_bus(16'h0001, 1'b0, 8'h55);
    push_bus(16'h0001, 1'b0, 8'hAA);
    push_bus(16'h0001, 1'b0, 8'h00);
    push_bus(16'h0001, 1'b0, {7'b0, full});
    push_bus(16'h0001, 1'b0, save);
    if (VERIFY) push_bus(16'h0001, 1'b1, 8'h00);
    e = '{is_done: 1'b1, addr: 16'h0, rw: 1'b0, data: 8'h00, when: cyc + lat,
          err: VERIFY && (ver != want), saved: save};
    exp_q.push_back(e);
  endtask

  task automatic start(input bit full);
    bus.req     = 1'b1;
    bus.full_en = full;
    @(posedge clk); #1;
    bus.req     = 1'b0;
    bus.full_en = ~full;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(!bus.busy, "seq_finish", bus.busy, 0);
    @(posedge clk); #1;
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_write(input logic [7:0] data, input int budget);
    int n;
    n = 0;
    while (!(bus.bus_en && !bus.r_w && bus.data_out == data) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(bus.bus_en && !bus.r_w && bus.data_out == data, "reach_write", bus.data_out, data);
  endtask

  task automatic check_reset(input string tag);
    check(bus.address == 16'h0000, {tag, "_address"}, bus.address, 0);
    check(bus.data_out == 8'h00, {tag, "_data_out"}, bus.data_out, 0);
    check(bus.r_w == 1'b1, {tag, "_r_w"}, bus.r_w, 1);
    check(bus.bus_en == 1'b0, {tag, "_bus_en"}, bus.bus_en, 0);
    check(bus.busy == 1'b0, {tag, "_busy"}, bus.busy, 0);
    check(bus.done == 1'b0, {tag, "_done"}, bus.done, 0);
    check(bus.err == 1'b0, {tag, "_err"}, bus.err, 0);
    check(bus.saved_bank == 8'h00, {tag, "_saved_bank"}, bus.saved_bank, 0);
  endtask

  task automatic run_seq(input bit full, input logic [7:0] save, input logic [7:0] ver);
    rd_save = save;
    rd_ver  = ver;
    rd_idx  = 0;
    push_seq(full, save, ver, SEQ_LAT);
    start(full);
    wait_idle(40);
  endtask

  initial begin : stim
    int dc;
    bus.req     = 1'b0;
    bus.full_en = 1'b0;
    bus._rdy    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full mode, clean readback
    dc = done_cnt;
    run_seq(1'b1, 8'h3C, 8'h3C);
    check(done_cnt == dc + 1, "done_count_full", done_cnt, dc + 1);
    check(bus.saved_bank == 8'h3C && bus.err == 1'b0, "full_final", {bus.saved_bank, bus.err}, {8'h3C, 1'b0});

    // nibble mode, good and bad readback
    run_seq(1'b0, 8'hA5, 8'h05);
    run_seq(1'b0, 8'hA5, 8'hA5);

    // 3-cycle stall during WR_K1
    rd_save = 8'h3C; rd_ver = 8'h3C; rd_idx = 0;
    push_seq(1'b1, 8'h3C, 8'h3C, SEQ_LAT + 3);
    start(1'b1);
    wait_write(8'hAA, 20);
    bus._rdy = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check(bus.address == 16'h0001 && bus.data_out == 8'hAA && bus.bus_en && !bus.r_w,
            "stall_hold", {bus.address, bus.data_out}, {16'h0001, 8'hAA});
    end
    bus._rdy = 1'b1;
    wait_idle(40);

    // timeout in WR_K2: partial sequence, no done
    rd_save = 8'h3C; rd_idx = 0;
    push_bus(16'h0001, 1'b1, 8'h00);
    push_bus(16'h0001, 1'b0, 8'h55);
    push_bus(16'h0001, 1'b0, 8'hAA);
    dc = done_cnt;
    start(1'b1);
    wait_write(8'h00, 20);
    bus._rdy = 1'b0;
    repeat (254) @(posedge clk);
    #1;
    check(bus.bus_en && !bus.err, "timeout_not_early", {bus.bus_en, bus.err}, 2'b10);
    @(posedge clk); #1;
    check(bus.err == 1'b1, "timeout_err", bus.err, 1);
    check(!bus.bus_en && !bus.busy && bus.address == 16'h0000, "timeout_idle",
          {bus.bus_en, bus.busy, bus.address}, 0);
    bus._rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check(bus.err == 1'b1, "err_sticky", bus.err, 1);
    check(done_cnt == dc, "timeout_no_done", done_cnt, dc);
    check(exp_q.size() == 0, "timeout_queue", exp_q.size(), 0);

    // async reset during WR_FLAG, then a clean run
    rd_save = 8'h3C; rd_idx = 0;
    push_bus(16'h0001, 1'b1, 8'h00);
    push_bus(16'h0001, 1'b0, 8'h55);
    push_bus(16'h0001, 1'b0, 8'hAA);
    push_bus(16'h0001, 1'b0, 8'h00);
    start(1'b1);
    wait_write(8'h01, 20);
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check(exp_q.size() == 0, "reset_queue", exp_q.size(), 0);
    run_seq(1'b0, 8'h5A, 8'h0A);

    // req while busy is ignored (mode change must not leak into the flag write)
    rd_save = 8'h77; rd_ver = 8'h77; rd_idx = 0;
    dc = done_cnt;
    push_seq(1'b1, 8'h77, 8'h77, SEQ_LAT);
    start(1'b1);
    repeat (2) @(posedge clk);
    #1;
    bus.req = 1'b1; bus.full_en = 1'b0;
    @(posedge clk); #1;
    bus.req = 1'b0;
    wait_idle(40);
    repeat (10) @(posedge clk);
    #1;
    check(done_cnt == dc + 1, "busy_req_one_done", done_cnt, dc + 1);
    check(!bus.busy, "busy_req_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
